dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 69 ++++++
 tb/tb_dmem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin/fixed-priority arbiter sharing one single-port data memory
module dmem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_nx;
  logic start, pick, winner, winner_nx, last_winner, last_winner_nx;
  logic ack0_nx, ack1_nx, rw_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx, rdata_nx;
  assign start = state == IDLE && (req0 || req1);
  assign pick  = req1 && (!req0 || (!FIXED_PRIO && !last_winner));
  assign busy  = state != IDLE;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? ACCESS : IDLE) : state == ACCESS ? ACK : IDLE;
  always_comb begin
    winner_nx      = start ? pick : winner;
    last_winner_nx = state == ACK ? winner : last_winner;
    ack0_nx        = state == ACK && !winner;
    ack1_nx        = state == ACK && winner;
    rw_nx          = start && (pick ? we1 : we0);
    addr_nx        = start ? (pick ? addr1 : addr0) : mem_addr;
    wdata_nx       = start ? (pick ? wdata1 : wdata0) : mem_data_in;
    rdata_nx       = state == ACCESS && !mem_read_write ? mem_data_out : rdata;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      winner         <= 1'b0;
      last_winner    <= 1'b1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      mem_read_write <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      rdata          <= '0;
    end else begin
      winner         <= winner_nx;
      last_winner    <= last_winner_nx;
      ack0           <= ack0_nx;
      ack1           <= ack1_nx;
      mem_read_write <= rw_nx;
      mem_addr       <= addr_nx;
      mem_data_in    <= wdata_nx;
      rdata          <= rdata_nx;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, sw = 1'b0;
  logic [8:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, busy, mem_rw;
  logic [8:0] mem_addr;
  logic [15:0] rdata, mem_din, mem_dout;
  logic rq0f = 1'b0, rq1f = 1'b0, ack0f, ack1f, busyf, mem_rwf;
  logic [8:0] mem_addrf;
  logic [15:0] rdataf, mem_dinf;
  logic [15:0] mem [512];
  logic [15:0] rd;
  int checks = 0, errors = 0, rw_cycles = 0, rw0, lat, both, a0f, a1f_at;
  int t0[$], t1[$];
  dmem_arbiter #(.ADDR_W(9), .DATA_W(16), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mem_read_write(mem_rw), .mem_addr(mem_addr),
    .mem_data_in(mem_din), .mem_data_out(mem_dout)
  );
  dmem_arbiter #(.ADDR_W(9), .DATA_W(16), .FIXED_PRIO(1'b1)) dutf (
    .clk(clk), .rst_n(rst_n),
    .req0(rq0f), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0f),
    .req1(rq1f), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1f),
    .rdata(rdataf), .busy(busyf), .mem_read_write(mem_rwf), .mem_addr(mem_addrf),
    .mem_data_in(mem_dinf), .mem_data_out(16'h0000)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rw) mem[mem_addr] <= mem_din;
  assign mem_dout = (mem_addr == 9'd4) ? {15'b0, sw} : mem[mem_addr];
  always @(negedge clk) if (mem_rw) rw_cycles++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_acc(input bit p, input bit we, input logic [8:0] a, input logic [15:0] d,
                        output int l, output logic [15:0] r);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    l = 0;
    do begin @(negedge clk); l++; end while (!(p ? ack1 : ack0) && l < 20);
    r = rdata;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data_in", 32'(mem_din), 0);
    repeat (4) @(negedge clk);
    chk("idle_rw_never", 32'(rw_cycles), 0);
    chk("idle_busy", 32'(busy), 0);
    rw0 = rw_cycles;
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'h010; wdata0 = 16'hBEEF;
    @(negedge clk);
    chk("wr_access_rw", 32'(mem_rw), 1);
    chk("wr_access_addr", 32'(mem_addr), 'h010);
    chk("wr_access_data", 32'(mem_din), 'hBEEF);
    chk("wr_access_busy", 32'(busy), 1);
    @(negedge clk);
    chk("wr_ackstate_rw", 32'(mem_rw), 0);
    chk("wr_ack0_early", 32'(ack0), 0);
    @(negedge clk);
    chk("wr_ack0", 32'(ack0), 1);
    chk("wr_ack1_quiet", 32'(ack1), 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("wr_ack0_pulse", 32'(ack0), 0);
    chk("wr_busy_done", 32'(busy), 0);
    chk("wr_rw_once", 32'(rw_cycles - rw0), 1);
    chk("wr_mem", 32'(mem[16]), 'hBEEF);
    chk("wr_rdata_kept", 32'(rdata), 0);
    rw0 = rw_cycles;
    do_acc(1'b0, 1'b0, 9'h010, 16'h0000, lat, rd);
    chk("rd_lat", 32'(lat), 3);
    chk("rd_data", 32'(rd), 'hBEEF);
    chk("rd_no_rw", 32'(rw_cycles - rw0), 0);
    do_acc(1'b1, 1'b1, 9'h1FF, 16'h1234, lat, rd);
    chk("wr1_lat", 32'(lat), 3);
    chk("wr1_rdata_kept", 32'(rd), 'hBEEF);
    do_acc(1'b1, 1'b0, 9'h1FF, 16'h0000, lat, rd);
    chk("rd1_top_addr", 32'(rd), 'h1234);
    do_acc(1'b1, 1'b1, 9'h000, 16'h0001, lat, rd);
    chk("led_on", 32'(mem[0][0]), 1);
    sw = 1'b1;
    do_acc(1'b0, 1'b0, 9'h004, 16'h0000, lat, rd);
    chk("switch_read", 32'(rd), 'h0001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h1FF;
    both = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack0) t0.push_back(k);
      if (ack1) t1.push_back(k);
      if (ack0 && ack1) both++;
    end
    chk("rr_rdata_last", 32'(rdata), 'h1234);
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_ack0_count", 32'(t0.size()), 2);
    chk("rr_ack1_count", 32'(t1.size()), 2);
    chk("rr_first_port0", 32'(t0.size() > 0 ? t0[0] : 0), 3);
    chk("rr_then_port1", 32'(t1.size() > 0 ? t1[0] : 0), 6);
    chk("rr_ack0_spacing", 32'(t0.size() > 1 ? t0[1] - t0[0] : 0), 6);
    chk("rr_ack1_spacing", 32'(t1.size() > 1 ? t1[1] - t1[0] : 0), 6);
    chk("rr_no_overlap", 32'(both), 0);
    repeat (2) @(negedge clk);
    chk("rr_idle_after", 32'(busy), 0);
    rq0f = 1'b1; rq1f = 1'b1;
    a0f = 0; a1f_at = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (ack0f) a0f++;
      if (ack1f && a1f_at == 0) a1f_at = k;
      if (k == 9) rq0f = 1'b0;
      if (ack1f) rq1f = 1'b0;
    end
    chk("fp_port0_served", 32'(a0f), 3);
    chk("fp_port1_after_drop", 32'(a1f_at), 12);
    chk("fp_idle_after", 32'(busyf), 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    @(negedge clk);
    chk("mid_access_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack0", 32'(ack0), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_idle", 32'(busy), 0);
    rst_n = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack0 && lat < 20);
    req0 = 1'b0;
    chk("mid_reserve_lat", 32'(lat), 3);
    chk("mid_reserve_data", 32'(rdata), 'hBEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
